// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types for the issue-queue bank: slot record layout and fixed widths.
package issue_pkg;

    localparam int ISQ_SRC_NUM    = 2;
    localparam int ISQ_TAG_WIDTH  = 6;
    localparam int ISQ_DATA_WIDTH = 32;

    typedef struct packed {
        logic                                       valid;
        logic [ISQ_SRC_NUM-1:0][ISQ_TAG_WIDTH-1:0]  src_tag;
        logic [ISQ_SRC_NUM-1:0]                     src_rdy;
        logic [ISQ_DATA_WIDTH-1:0]                  data;
    } isq_entry_t;

endpackage

// File: rtl/issue_queue_ctrl_if.sv
// Handshake bundle of one issue-queue bank: dispatch, wakeup, age-matrix and register-read sides.
interface issue_queue_ctrl_if #(
    parameter int DEPTH      = 8,
    parameter int TAG_WIDTH  = 6,
    parameter int WB_NUM     = 2,
    parameter int DATA_WIDTH = 32
);
    logic                               flush;
    logic                               enq_valid;
    logic                               enq_ready;
    logic [1:0][TAG_WIDTH-1:0]          enq_src_tag;
    logic [1:0]                         enq_src_rdy;
    logic [DATA_WIDTH-1:0]              enq_data;
    logic [WB_NUM-1:0]                  wb_valid;
    logic [WB_NUM-1:0][TAG_WIDTH-1:0]   wb_tag;
    logic                               age_en;
    logic [DEPTH-1:0]                   age_idx;
    logic [DEPTH-1:0]                   entry_ready;
    logic [DEPTH-1:0]                   age_select;
    logic                               issue_valid;
    logic                               issue_ready;
    logic [DATA_WIDTH-1:0]              issue_data;

    modport slave (
        input  flush, enq_valid, enq_src_tag, enq_src_rdy, enq_data,
        input  wb_valid, wb_tag, age_select, issue_ready,
        output enq_ready, age_en, age_idx, entry_ready, issue_valid, issue_data
    );

    modport master (
        output flush, enq_valid, enq_src_tag, enq_src_rdy, enq_data,
        output wb_valid, wb_tag, age_select, issue_ready,
        input  enq_ready, age_en, age_idx, entry_ready, issue_valid, issue_data
    );
endinterface

// File: rtl/issue_queue_ctrl_free_finder.sv
// Picks the lowest-index free slot as a one-hot vector and flags whether any slot is free.
module isq_free_finder
    import issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] free_oh,
    output logic             any_free
);

    logic [DEPTH-1:0] free_s;

    // Two's-complement trick isolates the lowest set bit of the free vector.
    always_comb begin
        free_s   = ~valid;
        free_oh  = free_s & (~free_s + {{(DEPTH-1){1'b0}}, 1'b1});
        any_free = |free_s;
    end

endmodule

// File: rtl/issue_queue_ctrl.sv
// Entry-state controller of one issue-queue bank (allocation, wakeup, issue, flush).
// Optional ISQ_PERF_EN adds saturating issue/full-stall performance counters.
module issue_queue_ctrl
    import issue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int TAG_WIDTH  = ISQ_TAG_WIDTH,
    parameter int WB_NUM     = 2,
    parameter int DATA_WIDTH = ISQ_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ISQ_PERF_EN
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_full_cnt,
`endif
    issue_queue_ctrl_if.slave   bus
);

    isq_entry_t             slots_r [DEPTH];
    isq_entry_t             enq_entry_s;
    logic [DEPTH-1:0]       valid_s;
    logic [DEPTH-1:0]       ready_s;
    logic [DEPTH-1:0]       alloc_oh_s;
    logic                   any_free_s;
    logic                   enq_fire_s;
    logic                   issue_valid_s;
    logic                   issue_fire_s;
    logic [DATA_WIDTH-1:0]  issue_data_s;

    function automatic logic tag_woken(
        input logic [TAG_WIDTH-1:0]             tag,
        input logic [WB_NUM-1:0]                wb_v,
        input logic [WB_NUM-1:0][TAG_WIDTH-1:0] wb_t
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_NUM; w++) begin
            if (wb_v[w] && (wb_t[w] == tag)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    isq_free_finder #(.DEPTH(DEPTH)) u_free_finder (
        .valid    (valid_s),
        .free_oh  (alloc_oh_s),
        .any_free (any_free_s)
    );

    // Per-slot status vectors and the payload mux driven by the age-matrix selection.
    always_comb begin
        valid_s      = '0;
        ready_s      = '0;
        issue_data_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i] = slots_r[i].valid;
            ready_s[i] = slots_r[i].valid & (&slots_r[i].src_rdy);
            if (bus.age_select[i]) begin
                issue_data_s = issue_data_s | slots_r[i].data;
            end else begin
                issue_data_s = issue_data_s;
            end
        end
    end

    // Incoming entry, catching wakeups broadcast in the same cycle as dispatch.
    always_comb begin
        enq_entry_s         = '0;
        enq_entry_s.valid   = 1'b1;
        enq_entry_s.src_tag = bus.enq_src_tag;
        enq_entry_s.data    = bus.enq_data;
        for (int k = 0; k < ISQ_SRC_NUM; k++) begin
            enq_entry_s.src_rdy[k] = bus.enq_src_rdy[k]
                                   | tag_woken(bus.enq_src_tag[k], bus.wb_valid, bus.wb_tag);
        end
    end

    // Handshake qualification; flush squashes both sides, reset suppresses allocation strobes.
    always_comb begin
        enq_fire_s    = bus.enq_valid & any_free_s & ~bus.flush & ~rst;
        issue_valid_s = |bus.age_select;
        issue_fire_s  = issue_valid_s & bus.issue_ready & ~bus.flush;
    end

    assign bus.enq_ready   = any_free_s;
    assign bus.age_en      = enq_fire_s;
    assign bus.age_idx     = enq_fire_s ? alloc_oh_s : {DEPTH{1'b0}};
    assign bus.entry_ready = ready_s;
    assign bus.issue_valid = issue_valid_s;
    assign bus.issue_data  = issue_data_s;

    // Slot state: allocation only targets free slots, so it never collides with issue/wakeup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_fire_s && alloc_oh_s[i]) begin
                    slots_r[i] <= enq_entry_s;
                end else if (slots_r[i].valid) begin
                    if (issue_fire_s && bus.age_select[i]) begin
                        slots_r[i].valid <= 1'b0;
                    end
                    for (int k = 0; k < ISQ_SRC_NUM; k++) begin
                        if (tag_woken(slots_r[i].src_tag[k], bus.wb_valid, bus.wb_tag)) begin
                            slots_r[i].src_rdy[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef ISQ_PERF_EN
    // Saturating event counters; only rst clears them, flush does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= 32'd0;
            perf_full_cnt  <= 32'd0;
        end else begin
            if (issue_fire_s && (perf_issue_cnt != 32'hFFFF_FFFF)) begin
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            end
            if (bus.enq_valid && !any_free_s && (perf_full_cnt != 32'hFFFF_FFFF)) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
